// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory port bundle for imem_loader.
// The master side is the loader; the slave side is the byte source plus IMEM.
interface imem_loader_if #(
   parameter int DEPTH = 10
) ();

   // Upstream byte stream (valid/ready)
   logic             byte_valid;
   logic [7:0]       byte_data;
   logic             byte_ready;

   // Instruction memory port
   logic [DEPTH-1:0] imem_addr;
   logic [31:0]      imem_wdata;
   logic             imem_we;
   logic [31:0]      imem_rdata;

   modport master (
      input  byte_valid,
      input  byte_data,
      output byte_ready,
      output imem_addr,
      output imem_wdata,
      output imem_we,
      input  imem_rdata
   );

   modport slave (
      output byte_valid,
      output byte_data,
      input  byte_ready,
      input  imem_addr,
      input  imem_wdata,
      input  imem_we,
      output imem_rdata
   );

endinterface

// File: rtl/imem_loader.sv
// Program loader: assembles little-endian words from a byte stream, writes
// them to consecutive IMEM addresses, reads each one back, and keeps a
// running 32-bit checksum of the words that verified correctly.
module imem_loader #(
   parameter int DEPTH = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DEPTH-1:0] base_addr,
   input  logic [DEPTH:0]   word_count,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [31:0]      checksum,
   imem_loader_if.master    bus
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RECV   = 3'd1,
      ST_WRITE  = 3'd2,
      ST_VERIFY = 3'd3,
      ST_DONE   = 3'd4,
      ST_ERR    = 3'd5
   } state_t;

   localparam logic [DEPTH:0] IDX_ONE  = {{DEPTH{1'b0}}, 1'b1};
   localparam logic [DEPTH:0] IDX_ZERO = {(DEPTH+1){1'b0}};

   // Places one byte into its lane of a little-endian word.
   function automatic logic [31:0] insert_byte(
      input logic [31:0] word,
      input logic [1:0]  lane,
      input logic [7:0]  data
   );
      logic [31:0] res;
      res = word;
      case (lane)
         2'd0:    res[7:0]   = data;
         2'd1:    res[15:8]  = data;
         2'd2:    res[23:16] = data;
         2'd3:    res[31:24] = data;
         default: res        = word;
      endcase
      return res;
   endfunction

   // Registered state
   state_t           state_r;
   logic [DEPTH-1:0] base_r;
   logic [DEPTH:0]   count_r;
   logic [DEPTH:0]   idx_r;
   logic [1:0]       cnt_r;
   logic [31:0]      word_r;
   logic [31:0]      sum_r;
   logic             error_r;
   logic [DEPTH-1:0] addr_r;
   logic             we_r;
   logic             ready_r;
   logic             busy_r;
   logic             done_r;

   // Next-state values
   state_t           state_s;
   logic [DEPTH-1:0] base_s;
   logic [DEPTH:0]   count_s;
   logic [DEPTH:0]   idx_s;
   logic [1:0]       cnt_s;
   logic [31:0]      word_s;
   logic [31:0]      sum_s;
   logic             error_s;
   logic [DEPTH-1:0] addr_s;
   logic [DEPTH:0]   idx_inc_s;
   logic             rdata_bad_s;

   assign idx_inc_s   = idx_r + IDX_ONE;
   assign rdata_bad_s = (bus.imem_rdata != word_r);

   // Next-state and datapath decisions for the load sequence.
   always_comb begin
      state_s = state_r;
      base_s  = base_r;
      count_s = count_r;
      idx_s   = idx_r;
      cnt_s   = cnt_r;
      word_s  = word_r;
      sum_s   = sum_r;
      error_s = error_r;
      addr_s  = addr_r;

      case (state_r)
         ST_IDLE: begin
            if (start) begin
               base_s  = base_addr;
               count_s = word_count;
               idx_s   = IDX_ZERO;
               cnt_s   = 2'd0;
               word_s  = 32'd0;
               sum_s   = 32'd0;
               error_s = 1'b0;
               if (word_count == IDX_ZERO) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_RECV;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_RECV: begin
            if (bus.byte_valid) begin
               word_s = insert_byte(word_r, cnt_r, bus.byte_data);
               cnt_s  = cnt_r + 2'd1;
               if (cnt_r == 2'd3) begin
                  // Address is captured here so it is stable for WRITE and VERIFY.
                  addr_s  = base_r + idx_r[DEPTH-1:0];
                  state_s = ST_WRITE;
               end else begin
                  state_s = ST_RECV;
               end
            end else begin
               state_s = ST_RECV;
            end
         end

         ST_WRITE: begin
            state_s = ST_VERIFY;
         end

         ST_VERIFY: begin
            if (rdata_bad_s) begin
               // Checksum only ever covers words that read back correctly.
               error_s = 1'b1;
               state_s = ST_ERR;
            end else begin
               sum_s = sum_r + word_r;
               idx_s = idx_inc_s;
               if (idx_inc_s == count_r) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_RECV;
               end
            end
         end

         ST_DONE: begin
            state_s = ST_IDLE;
         end

         ST_ERR: begin
            state_s = ST_IDLE;
         end

         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Load context, byte assembly, checksum and sticky error.
   always_ff @(posedge clk) begin
      if (rst) begin
         base_r  <= {DEPTH{1'b0}};
         count_r <= IDX_ZERO;
         idx_r   <= IDX_ZERO;
         cnt_r   <= 2'd0;
         word_r  <= 32'd0;
         sum_r   <= 32'd0;
         error_r <= 1'b0;
         addr_r  <= {DEPTH{1'b0}};
      end else begin
         base_r  <= base_s;
         count_r <= count_s;
         idx_r   <= idx_s;
         cnt_r   <= cnt_s;
         word_r  <= word_s;
         sum_r   <= sum_s;
         error_r <= error_s;
         addr_r  <= addr_s;
      end
   end

   // Control outputs registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         we_r    <= 1'b0;
         ready_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         we_r    <= (state_s == ST_WRITE);
         ready_r <= (state_s == ST_RECV);
         busy_r  <= (state_s != ST_IDLE);
         done_r  <= (state_s == ST_DONE);
      end
   end

   assign bus.byte_ready = ready_r;
   assign bus.imem_addr  = addr_r;
   assign bus.imem_wdata = word_r;
   assign bus.imem_we    = we_r;
   assign busy           = busy_r;
   assign done           = done_r;
   assign error          = error_r;
   assign checksum       = sum_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader with a behavioural IMEM model.
module tb_imem_loader;

   logic        clk;
   logic        rst;
   logic        start;
   logic [9:0]  base_addr;
   logic [10:0] word_count;
   logic        busy;
   logic        done;
   logic        error;
   logic [31:0] checksum;
   logic        force_bad;

   logic [31:0] mem [0:1023];

   int cyc;
   int done_n;
   int done_cyc;
   int we_cnt;
   int start_cyc;
   int errors;
   int checks;
   int done_snap;
   int we_snap;

   imem_loader_if #(.DEPTH(10)) bus ();

   imem_loader #(.DEPTH(10)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .checksum   (checksum),
      .bus        (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // IMEM model: synchronous write, combinational read, optional corruption.
   always @(posedge clk) begin
      if (bus.imem_we) mem[bus.imem_addr] <= bus.imem_wdata;
   end
   assign bus.imem_rdata = force_bad ? 32'hDEADBEEF : mem[bus.imem_addr];

   // Cycle counter plus done / write-enable monitors.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (done) begin
         done_n   <= done_n + 1;
         done_cyc <= cyc;
      end
      if (bus.imem_we) we_cnt <= we_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [9:0] b, input logic [10:0] n);
      base_addr  = b;
      word_count = n;
      start      = 1'b1;
      start_cyc  = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int guard;
      guard = 0;
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      @(negedge clk);
      while (!bus.byte_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("byte_accept_timeout", 32'(guard < 100), 32'd1);
      @(posedge clk); #1;
      bus.byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
   endtask

   task automatic wait_idle();
      int g;
      g = 0;
      while (busy && g < 200) begin
         @(posedge clk); #1;
         g++;
      end
      check("idle_timeout", 32'(g < 200), 32'd1);
   endtask

   initial begin
      cyc = 0; done_n = 0; done_cyc = 0; we_cnt = 0;
      errors = 0; checks = 0; start_cyc = 0;
      rst = 1'b1; start = 1'b0; base_addr = 10'd0; word_count = 11'd0;
      force_bad = 1'b0;
      bus.byte_valid = 1'b0; bus.byte_data = 8'd0;

      // Reset values
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
      check("rst_imem_we",    32'(bus.imem_we),    32'd0);
      check("rst_imem_addr",  32'(bus.imem_addr),  32'd0);
      check("rst_imem_wdata", bus.imem_wdata,      32'd0);
      check("rst_busy",       32'(busy),           32'd0);
      check("rst_done",       32'(done),           32'd0);
      check("rst_error",      32'(error),          32'd0);
      check("rst_checksum",   checksum,            32'd0);

      // Single word
      done_snap = done_n; we_snap = we_cnt;
      do_start(10'h010, 11'd1);
      check("single_busy",  32'(busy),           32'd1);
      check("single_ready", 32'(bus.byte_ready), 32'd1);
      send_word(32'h12345678);
      check("single_write_we",    32'(bus.imem_we),   32'd1);
      check("single_write_addr",  32'(bus.imem_addr), 32'h010);
      check("single_write_wdata", bus.imem_wdata,     32'h12345678);
      check("single_write_ready", 32'(bus.byte_ready), 32'd0);
      @(posedge clk); #1;
      check("single_verify_we",   32'(bus.imem_we),   32'd0);
      check("single_verify_addr", 32'(bus.imem_addr), 32'h010);
      wait_idle();
      check("single_mem",        mem[10'h010],             32'h12345678);
      check("single_we_count",   32'(we_cnt - we_snap),    32'd1);
      check("single_checksum",   checksum,                 32'h12345678);
      check("single_done_count", 32'(done_n - done_snap),  32'd1);
      check("single_done_delay", 32'(done_cyc - start_cyc), 32'd7);
      check("single_done_low",   32'(done),                32'd0);
      check("single_error",      32'(error),               32'd0);
      check("single_addr_hold",  32'(bus.imem_addr),       32'h010);

      // Wrap-around with checksum overflow
      we_snap = we_cnt;
      do_start(10'h3FF, 11'd2);
      send_word(32'hF0000001);
      send_word(32'h20000003);
      wait_idle();
      check("wrap_mem_hi",     mem[10'h3FF],             32'hF0000001);
      check("wrap_mem_lo",     mem[10'h000],             32'h20000003);
      check("wrap_checksum",   checksum,                 32'h10000004);
      check("wrap_we_count",   32'(we_cnt - we_snap),    32'd2);
      check("wrap_done_delay", 32'(done_cyc - start_cyc), 32'd13);

      // Backpressure: 3-cycle gap between bytes 1 and 2, bytes offered after the word
      we_snap = we_cnt;
      do_start(10'h020, 11'd1);
      send_byte(8'h0D);
      send_byte(8'hF0);
      repeat (3) @(posedge clk);
      #1;
      send_byte(8'hFE);
      send_byte(8'hCA);
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'h55;
      wait_idle();
      repeat (2) @(posedge clk);
      #1 bus.byte_valid = 1'b0;
      check("bp_mem",        mem[10'h020],             32'hCAFEF00D);
      check("bp_checksum",   checksum,                 32'hCAFEF00D);
      check("bp_we_count",   32'(we_cnt - we_snap),    32'd1);
      check("bp_done_delay", 32'(done_cyc - start_cyc), 32'd10);

      // Readback mismatch on word 0
      done_snap = done_n; we_snap = we_cnt;
      force_bad = 1'b1;
      do_start(10'h040, 11'd2);
      send_word(32'h44332211);
      wait_idle();
      force_bad = 1'b0;
      check("mis_error",      32'(error),              32'd1);
      check("mis_busy",       32'(busy),               32'd0);
      check("mis_no_done",    32'(done_n - done_snap), 32'd0);
      check("mis_checksum",   checksum,                32'd0);
      check("mis_we_count",   32'(we_cnt - we_snap),   32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("mis_error_sticky", 32'(error), 32'd1);

      // Zero count: done one cycle after start, no write, error cleared
      done_snap = done_n; we_snap = we_cnt;
      do_start(10'h050, 11'd0);
      check("zero_error_clear", 32'(error), 32'd0);
      check("zero_done_now",    32'(done),  32'd1);
      wait_idle();
      check("zero_done_delay", 32'(done_cyc - start_cyc), 32'd1);
      check("zero_done_count", 32'(done_n - done_snap),   32'd1);
      check("zero_no_write",   32'(we_cnt - we_snap),     32'd0);

      // Reset after 2 bytes of word 1 of a 3-word load
      we_snap = we_cnt;
      do_start(10'h080, 11'd3);
      send_word(32'h01020304);
      send_byte(8'hAA);
      send_byte(8'hBB);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mrst_we",       32'(bus.imem_we),    32'd0);
      check("mrst_busy",     32'(busy),           32'd0);
      check("mrst_ready",    32'(bus.byte_ready), 32'd0);
      check("mrst_checksum", checksum,            32'd0);
      repeat (4) @(posedge clk);
      #1;
      check("mrst_we_count", 32'(we_cnt - we_snap), 32'd1);
      check("mrst_mem_w0",   mem[10'h080],          32'h01020304);
      we_snap = we_cnt;
      do_start(10'h090, 11'd1);
      send_word(32'h0BADF00D);
      wait_idle();
      check("fresh_mem",        mem[10'h090],             32'h0BADF00D);
      check("fresh_checksum",   checksum,                 32'h0BADF00D);
      check("fresh_done_delay", 32'(done_cyc - start_cyc), 32'd7);
      check("fresh_we_count",   32'(we_cnt - we_snap),    32'd1);

      // Start while busy is ignored
      we_snap = we_cnt;
      do_start(10'h100, 11'd1);
      send_byte(8'h10);
      base_addr  = 10'h200;
      word_count = 11'd5;
      start      = 1'b1;
      send_byte(8'h32);
      start = 1'b0;
      send_byte(8'h54);
      send_byte(8'h76);
      check("ign_addr", 32'(bus.imem_addr), 32'h100);
      wait_idle();
      check("ign_mem",        mem[10'h100],             32'h76543210);
      check("ign_checksum",   checksum,                 32'h76543210);
      check("ign_done_delay", 32'(done_cyc - start_cyc), 32'd7);
      check("ign_we_count",   32'(we_cnt - we_snap),    32'd1);
      check("ign_busy",       32'(busy),                32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
